accessor: RTL and testbench

Memory-access stage of the in-order pipeline, between the executor and the writeback stage. It accepts one executor result at a time. Loads and stores run one transaction on the data-memory bus, with byte-lane steering and sign/zero extension. All other results pass through with their `rd`/`rd_data` unchanged. The result goes to writeback over a valid/ready handshake.

---
 rtl/accessor_pkg.sv | 48 ++++
 rtl/accessor_lane_align.sv | 62 ++++++
 rtl/accessor.sv | 176 +++++++++++++++++
 tb/tb_accessor.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accessor_pkg.sv
// accessor_pkg: shared types for the memory-access stage.
//   executor_output : result handed over by the executor
//   accessor_output : result handed to writeback {rd, rd_data, misaligned}
//   state_e         : accessor FSM states
//   size_e          : access size decoded from the is_* flags
//   store_lanes     : byte-lane steered store request (strobe + data)
package accessor_pkg;

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] rd_data;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_data;
        logic            is_lb;
        logic            is_lbu;
        logic            is_lh;
        logic            is_lhu;
        logic            is_lw;
        logic            is_sb;
        logic            is_sh;
        logic            is_sw;
    } executor_output;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] rd_data;
        logic            misaligned;
    } accessor_output;

    typedef enum logic {
        StIdle,
        StMem
    } state_e;

    typedef enum logic [1:0] {
        SzByte,
        SzHalf,
        SzWord
    } size_e;

    typedef struct packed {
        logic [3:0]      wstrb;
        logic [XLEN-1:0] wdata;
    } store_lanes;

endpackage

// File: rtl/accessor_lane_align.sv
// lane_align: combinational byte-lane steering for the accessor.
//   Store side: i_st_off, i_st_size, i_st_data -> o_wstrb, o_wdata (lane-replicated)
//   Load side : i_rdata, i_ld_off, i_ld_size, i_ld_signed -> o_rd_data (extended)
module lane_align
    import accessor_pkg::*;
(
    input  logic [1:0]      i_st_off,
    input  size_e           i_st_size,
    input  logic [XLEN-1:0] i_st_data,
    output logic [3:0]      o_wstrb,
    output logic [XLEN-1:0] o_wdata,
    input  logic [1:0]      i_ld_off,
    input  size_e           i_ld_size,
    input  logic            i_ld_signed,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_rd_data
);

    function automatic store_lanes store_align(input logic [1:0] off, input size_e size,
                                               input logic [XLEN-1:0] data);
        store_lanes s;
        unique case (size)
            SzByte: begin
                s.wstrb = 4'b0001 << off;
                s.wdata = {4{data[7:0]}};
            end
            SzHalf: begin
                s.wstrb = 4'b0011 << off;
                s.wdata = {2{data[15:0]}};
            end
            default: begin
                s.wstrb = 4'b1111;
                s.wdata = data;
            end
        endcase
        return s;
    endfunction

    function automatic logic [XLEN-1:0] load_align(input logic [XLEN-1:0] rdata,
                                                   input logic [1:0] off, input size_e size,
                                                   input logic sgn);
        logic [XLEN-1:0] lane;
        logic [XLEN-1:0] res;
        lane = rdata >> {off, 3'b000};
        unique case (size)
            SzByte:  res = {{24{sgn & lane[7]}}, lane[7:0]};
            SzHalf:  res = {{16{sgn & lane[15]}}, lane[15:0]};
            default: res = lane;
        endcase
        return res;
    endfunction

    store_lanes w_st;

    always_comb begin
        w_st      = store_align(i_st_off, i_st_size, i_st_data);
        o_wstrb   = w_st.wstrb;
        o_wdata   = w_st.wdata;
        o_rd_data = load_align(i_rdata, i_ld_off, i_ld_size, i_ld_signed);
    end

endmodule

// File: rtl/accessor.sv
// accessor: memory-access stage between executor and writeback.
//   clk, reset (sync, active-high)
//   executor_valid / accessor_ready : upstream handshake, `in` carries the result
//   accessor_valid / writeback_ready: downstream handshake, `out` carries the result
//   mem_valid/mem_ready/mem_addr/mem_wstrb/mem_wdata/mem_rdata: data-memory bus
module accessor
    import accessor_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            executor_valid,
    output logic            accessor_ready,
    output logic            accessor_valid,
    input  logic            writeback_ready,
    input  executor_output  in,
    output accessor_output  out,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    state_e          r_state, w_state_next;
    logic            r_valid, w_valid_next;
    accessor_output  r_out, w_out_next;
    logic            r_mem_valid, w_mem_valid_next;
    logic [XLEN-1:0] r_mem_addr, w_mem_addr_next;
    logic [3:0]      r_mem_wstrb, w_mem_wstrb_next;
    logic [XLEN-1:0] r_mem_wdata, w_mem_wdata_next;
    // Context of the outstanding request, needed to format the load result.
    logic [4:0]      r_rd, w_rd_next;
    logic [1:0]      r_off, w_off_next;
    size_e           r_size, w_size_next;
    logic            r_signed, w_signed_next;
    logic            r_is_load, w_is_load_next;

    logic            w_is_load, w_is_store, w_is_mem, w_signed, w_misaligned, w_accept;
    size_e           w_size;
    logic [3:0]      w_wstrb;
    logic [XLEN-1:0] w_wdata, w_load_data;

    assign w_is_load  = in.is_lb | in.is_lbu | in.is_lh | in.is_lhu | in.is_lw;
    assign w_is_store = in.is_sb | in.is_sh | in.is_sw;
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_signed   = in.is_lb | in.is_lh;
    assign w_size     = (in.is_lb | in.is_lbu | in.is_sb) ? SzByte :
                        (in.is_lh | in.is_lhu | in.is_sh) ? SzHalf : SzWord;
    assign w_misaligned = w_is_mem &&
                          ((w_size == SzHalf && in.mem_addr[0]) ||
                           (w_size == SzWord && in.mem_addr[1:0] != 2'b00));

    assign accessor_ready = (r_state == StIdle) && (!r_valid || writeback_ready);
    assign w_accept       = executor_valid && accessor_ready;

    lane_align u_lane_align (
        .i_st_off    (in.mem_addr[1:0]),
        .i_st_size   (w_size),
        .i_st_data   (in.mem_data),
        .o_wstrb     (w_wstrb),
        .o_wdata     (w_wdata),
        .i_ld_off    (r_off),
        .i_ld_size   (r_size),
        .i_ld_signed (r_signed),
        .i_rdata     (mem_rdata),
        .o_rd_data   (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_valid     <= 1'b0;
            r_out       <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wstrb <= '0;
            r_mem_wdata <= '0;
            r_rd        <= '0;
            r_off       <= '0;
            r_size      <= SzWord;
            r_signed    <= 1'b0;
            r_is_load   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_valid     <= w_valid_next;
            r_out       <= w_out_next;
            r_mem_valid <= w_mem_valid_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wstrb <= w_mem_wstrb_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_rd        <= w_rd_next;
            r_off       <= w_off_next;
            r_size      <= w_size_next;
            r_signed    <= w_signed_next;
            r_is_load   <= w_is_load_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_valid_next     = r_valid;
        w_out_next       = r_out;
        w_mem_valid_next = r_mem_valid;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wstrb_next = r_mem_wstrb;
        w_mem_wdata_next = r_mem_wdata;
        w_rd_next        = r_rd;
        w_off_next       = r_off;
        w_size_next      = r_size;
        w_signed_next    = r_signed;
        w_is_load_next   = r_is_load;

        // Consumed result drops unless a new one completes on the same edge below.
        if (r_valid && writeback_ready) begin
            w_valid_next = 1'b0;
        end

        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (!w_is_mem) begin
                        w_out_next   = '{rd: in.rd, rd_data: in.rd_data, misaligned: 1'b0};
                        w_valid_next = 1'b1;
                    end else if (w_misaligned) begin
                        w_out_next   = '{rd: 5'd0, rd_data: '0, misaligned: 1'b1};
                        w_valid_next = 1'b1;
                    end else begin
                        w_state_next     = StMem;
                        w_mem_valid_next = 1'b1;
                        w_mem_addr_next  = {in.mem_addr[XLEN-1:2], 2'b00};
                        w_mem_wstrb_next = w_is_store ? w_wstrb : 4'b0000;
                        w_mem_wdata_next = w_wdata;
                        w_rd_next        = in.rd;
                        w_off_next       = in.mem_addr[1:0];
                        w_size_next      = w_size;
                        w_signed_next    = w_signed;
                        w_is_load_next   = w_is_load;
                    end
                end
            end
            StMem: begin
                if (mem_ready) begin
                    w_state_next     = StIdle;
                    w_mem_valid_next = 1'b0;
                    w_valid_next     = 1'b1;
                    // Stores report rd=0 so writeback performs no register write.
                    if (r_is_load) begin
                        w_out_next = '{rd: r_rd, rd_data: w_load_data, misaligned: 1'b0};
                    end else begin
                        w_out_next = '0;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign accessor_valid = r_valid;
    assign out            = r_out;
    assign mem_valid      = r_mem_valid;
    assign mem_addr       = r_mem_addr;
    assign mem_wstrb      = r_mem_wstrb;
    assign mem_wdata      = r_mem_wdata;

`ifdef FORMAL
    a_req_stable: assert property (@(posedge clk) disable iff (reset)
        (r_mem_valid && !mem_ready) |=>
        (r_mem_valid && $stable(r_mem_addr) && $stable(r_mem_wstrb) && $stable(r_mem_wdata)));
    a_ready_in_mem: assert property (@(posedge clk)
        (r_state == StMem) |-> !accessor_ready);
    a_out_hold: assert property (@(posedge clk) disable iff (reset)
        (r_valid && !writeback_ready) |=> (r_valid && $stable(r_out)));
`endif

endmodule

// File: tb/tb_accessor.sv
module tb_accessor;
    import accessor_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    logic           executor_valid;
    logic           accessor_ready;
    logic           accessor_valid;
    logic           writeback_ready;
    executor_output in_s;
    accessor_output out_s;
    logic           mem_valid;
    logic           mem_ready;
    logic [31:0]    mem_addr;
    logic [3:0]     mem_wstrb;
    logic [31:0]    mem_wdata;
    logic [31:0]    mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    accessor dut (
        .clk             (clk),
        .reset           (reset),
        .executor_valid  (executor_valid),
        .accessor_ready  (accessor_ready),
        .accessor_valid  (accessor_valid),
        .writeback_ready (writeback_ready),
        .in              (in_s),
        .out             (out_s),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_addr        (mem_addr),
        .mem_wstrb       (mem_wstrb),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Op kinds: 0 non-memory, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 sb, 7 sh, 8 sw.
    function automatic executor_output mk_op(input int kind, input logic [4:0] rd,
                                             input logic [31:0] rd_data,
                                             input logic [31:0] addr, input logic [31:0] data);
        executor_output o;
        o = '0;
        o.rd = rd; o.rd_data = rd_data; o.mem_addr = addr; o.mem_data = data;
        case (kind)
            1: o.is_lb = 1'b1;
            2: o.is_lbu = 1'b1;
            3: o.is_lh = 1'b1;
            4: o.is_lhu = 1'b1;
            5: o.is_lw = 1'b1;
            6: o.is_sb = 1'b1;
            7: o.is_sh = 1'b1;
            8: o.is_sw = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    // Reference model: access width in bytes.
    function automatic int unsigned m_size(input int kind);
        if (kind == 1 || kind == 2 || kind == 6) return 1;
        if (kind == 3 || kind == 4 || kind == 7) return 2;
        if (kind == 5 || kind == 8) return 4;
        return 0;
    endfunction

    function automatic logic [3:0] m_wstrb(input int kind, input logic [31:0] addr);
        int unsigned sz = m_size(kind);
        int unsigned v;
        if (kind < 6) return 4'd0;
        v = ((1 << sz) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input int kind, input logic [31:0] data);
        if (kind == 6) return (data & 32'hFF) * 32'h0101_0101;
        if (kind == 7) return (data & 32'hFFFF) * 32'h0001_0001;
        return data;
    endfunction

    function automatic logic [31:0] m_load(input int kind, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int unsigned sz = m_size(kind);
        logic [31:0] v, mask;
        v = rdata >> (8 * (addr % 4));
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
        v = v & mask;
        if ((kind == 1 || kind == 3) && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one aligned memory op to completion with `waits` extra cycles before mem_ready.
    // Returns what was observed; callers do the comparisons.
    task automatic mem_txn(input executor_output op, input int waits, input logic [31:0] rdata,
                           output logic [31:0] o_addr, output logic [3:0] o_wstrb,
                           output logic [31:0] o_wdata, output bit o_stable,
                           output accessor_output o_res, output bit o_done);
        writeback_ready = 1'b1;
        in_s = op;
        executor_valid = 1'b1;
        step();
        executor_valid = 1'b0;
        in_s = mk_op(0, 5'($urandom), $urandom, $urandom, $urandom);
        o_addr = mem_addr; o_wstrb = mem_wstrb; o_wdata = mem_wdata;
        o_stable = mem_valid && !accessor_ready && !accessor_valid;
        for (int i = 0; i < waits; i++) begin
            mem_rdata = $urandom;
            step();
            if (!mem_valid || accessor_ready || accessor_valid || mem_addr !== o_addr ||
                mem_wstrb !== o_wstrb || mem_wdata !== o_wdata) o_stable = 1'b0;
        end
        mem_ready = 1'b1;
        mem_rdata = rdata;
        step();
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        o_res = out_s;
        o_done = accessor_valid && !mem_valid && accessor_ready;
    endtask

    task automatic test_reset();
        reset = 1'b1; executor_valid = 1'b0; writeback_ready = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0; in_s = '0;
        step(); step();
        reset = 1'b0;
        #1;
        n_cmp++; if (accessor_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_valid got=%b want=0", accessor_valid); end
        n_cmp++; if (out_s !== '0) begin n_err++;
            $display("FAIL reset_out got=%h want=0", out_s); end
        n_cmp++; if (mem_valid !== 1'b0 || mem_addr !== '0 || mem_wstrb !== '0 ||
                     mem_wdata !== '0) begin n_err++;
            $display("FAIL reset_bus got=%b/%h/%b/%h want=0", mem_valid, mem_addr, mem_wstrb,
                     mem_wdata); end
        n_cmp++; if (accessor_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_ready got=%b want=1", accessor_ready); end
    endtask

    task automatic test_passthrough();
        executor_output op;
        accessor_output exp;
        writeback_ready = 1'b1;
        op = mk_op(0, 5'd5, 32'h1234, $urandom, $urandom);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) op = mk_op(0, 5'($urandom), $urandom, $urandom, $urandom);
            in_s = op; executor_valid = 1'b1;
            #1;
            n_cmp++; if (accessor_ready !== 1'b1) begin n_err++;
                $display("FAIL pass_ready[%0d] got=%b want=1", i, accessor_ready); end
            step();
            exp = '{rd: op.rd, rd_data: op.rd_data, misaligned: 1'b0};
            n_cmp++; if (accessor_valid !== 1'b1 || out_s !== exp) begin n_err++;
                $display("FAIL pass_out[%0d] got=%b/%h want=1/%h", i, accessor_valid, out_s, exp);
            end
        end
        executor_valid = 1'b0;
        step();
        n_cmp++; if (accessor_valid !== 1'b0) begin n_err++;
            $display("FAIL pass_drop got=%b want=0", accessor_valid); end
    endtask

    task automatic test_store();
        logic [31:0] a, d, ga, gd; logic [3:0] gs; bit st, dn; accessor_output r;
        int kind, w;
        mem_txn(mk_op(6, 5'd9, 32'h55, 32'h1003, 32'hAB), 2, $urandom, ga, gs, gd, st, r, dn);
        n_cmp++; if (ga !== 32'h1000 || gs !== 4'b1000 || gd !== 32'hABAB_ABAB) begin n_err++;
            $display("FAIL sb_req got=%h/%b/%h want=00001000/1000/abababab", ga, gs, gd); end
        n_cmp++; if (!st || !dn || r !== '0) begin n_err++;
            $display("FAIL sb_result got=stable%0d done%0d out=%h want=1/1/0", st, dn, r); end
        for (int i = 0; i < 8; i++) begin
            kind = $urandom_range(6, 8);
            a = $urandom & ~(m_size(kind) - 1);
            d = $urandom;
            w = $urandom_range(0, 3);
            mem_txn(mk_op(kind, 5'($urandom), $urandom, a, d), w, $urandom, ga, gs, gd, st, r, dn);
            n_cmp++; if (ga !== {a[31:2], 2'b00} || gs !== m_wstrb(kind, a) ||
                         gd !== m_wdata(kind, d)) begin n_err++;
                $display("FAIL st_req[%0d] kind=%0d got=%h/%b/%h want=%h/%b/%h", i, kind, ga, gs,
                         gd, {a[31:2], 2'b00}, m_wstrb(kind, a), m_wdata(kind, d)); end
            n_cmp++; if (!st || !dn || r !== '0) begin n_err++;
                $display("FAIL st_res[%0d] got=stable%0d done%0d out=%h want=1/1/0", i, st, dn, r);
            end
        end
    endtask

    task automatic test_load();
        logic [31:0] a, rdv, ga, gd; logic [3:0] gs; bit st, dn; accessor_output r, exp;
        int kind, w; logic [4:0] rd;
        int fk[3] = '{1, 2, 3};
        logic [31:0] fa[3] = '{32'h2001, 32'h2001, 32'h3002};
        logic [31:0] fr[3] = '{32'h0000_8000, 32'h0000_8000, 32'h8001_0000};
        logic [31:0] fe[3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001};
        for (int i = 0; i < 3; i++) begin
            mem_txn(mk_op(fk[i], 5'd7, $urandom, fa[i], $urandom), 1, fr[i], ga, gs, gd, st, r,
                    dn);
            exp = '{rd: 5'd7, rd_data: fe[i], misaligned: 1'b0};
            n_cmp++; if (!dn || r !== exp || gs !== 4'd0) begin n_err++;
                $display("FAIL ld_fixed[%0d] got=done%0d out=%h wstrb=%b want=1/%h/0", i, dn, r,
                         gs, exp); end
        end
        for (int i = 0; i < 10; i++) begin
            kind = $urandom_range(1, 5);
            a = $urandom & ~(m_size(kind) - 1);
            rdv = $urandom;
            rd = (i == 0) ? 5'd0 : 5'($urandom);
            w = $urandom_range(0, 3);
            mem_txn(mk_op(kind, rd, $urandom, a, $urandom), w, rdv, ga, gs, gd, st, r, dn);
            exp = '{rd: rd, rd_data: m_load(kind, a, rdv), misaligned: 1'b0};
            n_cmp++; if (ga !== {a[31:2], 2'b00} || gs !== 4'd0 || !st) begin n_err++;
                $display("FAIL ld_req[%0d] got=%h/%b stable%0d want=%h/0/1", i, ga, gs, st,
                         {a[31:2], 2'b00}); end
            n_cmp++; if (!dn || r !== exp) begin n_err++;
                $display("FAIL ld_res[%0d] kind=%0d got=done%0d out=%h want=1/%h", i, kind, dn, r,
                         exp); end
        end
    endtask

    task automatic test_misaligned();
        int kind; logic [31:0] a;
        accessor_output exp;
        exp = '{rd: 5'd0, rd_data: 32'd0, misaligned: 1'b1};
        writeback_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                kind = 5; a = 32'h3001;
            end else begin
                kind = (i % 2 == 0) ? $urandom_range(3, 4) : (($urandom_range(0, 1) == 0) ? 5 : 8);
                a = $urandom;
                if (m_size(kind) == 2) a[0] = 1'b1;
                else a[1:0] = 2'($urandom_range(1, 3));
            end
            in_s = mk_op(kind, 5'($urandom), $urandom, a, $urandom);
            executor_valid = 1'b1;
            step();
            executor_valid = 1'b0;
            n_cmp++; if (mem_valid !== 1'b0 || accessor_valid !== 1'b1 || out_s !== exp) begin
                n_err++;
                $display("FAIL misaligned[%0d] kind=%0d got=mv%b v%b out=%h want=0/1/%h", i, kind,
                         mem_valid, accessor_valid, out_s, exp); end
            step();
            n_cmp++; if (accessor_valid !== 1'b0 || mem_valid !== 1'b0) begin n_err++;
                $display("FAIL misaligned_after[%0d] got=v%b mv%b want=0/0", i, accessor_valid,
                         mem_valid); end
        end
    endtask

    task automatic test_back_to_back();
        executor_output a, b;
        accessor_output ea, eb;
        a = mk_op(0, 5'($urandom), $urandom, $urandom, $urandom);
        b = mk_op(0, 5'($urandom), $urandom, $urandom, $urandom);
        ea = '{rd: a.rd, rd_data: a.rd_data, misaligned: 1'b0};
        eb = '{rd: b.rd, rd_data: b.rd_data, misaligned: 1'b0};
        writeback_ready = 1'b0;
        in_s = a; executor_valid = 1'b1;
        step();
        in_s = b;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (accessor_valid !== 1'b1 || out_s !== ea || accessor_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold[%0d] got=v%b out=%h rdy%b want=1/%h/0", i, accessor_valid,
                         out_s, accessor_ready, ea); end
            step();
        end
        writeback_ready = 1'b1;
        #1;
        n_cmp++; if (accessor_ready !== 1'b1) begin n_err++;
            $display("FAIL release_ready got=%b want=1", accessor_ready); end
        step();
        executor_valid = 1'b0;
        n_cmp++; if (accessor_valid !== 1'b1 || out_s !== eb) begin n_err++;
            $display("FAIL release_out got=v%b out=%h want=1/%h", accessor_valid, out_s, eb); end
        step();
        n_cmp++; if (accessor_valid !== 1'b0) begin n_err++;
            $display("FAIL release_drop got=%b want=0", accessor_valid); end
    endtask

    task automatic test_reset_mid_mem();
        writeback_ready = 1'b1;
        in_s = mk_op(5, 5'd3, $urandom, 32'h4000, $urandom);
        executor_valid = 1'b1;
        step();
        executor_valid = 1'b0;
        n_cmp++; if (mem_valid !== 1'b1) begin n_err++;
            $display("FAIL midrst_issue got=%b want=1", mem_valid); end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (mem_valid !== 1'b0 || accessor_valid !== 1'b0 || accessor_ready !== 1'b1)
        begin n_err++;
            $display("FAIL midrst_state got=mv%b v%b rdy%b want=0/0/1", mem_valid, accessor_valid,
                     accessor_ready); end
        mem_ready = 1'b1; mem_rdata = $urandom;
        step(); step();
        mem_ready = 1'b0;
        n_cmp++; if (accessor_valid !== 1'b0 || mem_valid !== 1'b0 || out_s !== '0) begin
            n_err++;
            $display("FAIL midrst_late_ready got=v%b mv%b out=%h want=0/0/0", accessor_valid,
                     mem_valid, out_s); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_store();
        test_load();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
